cross_bus_feeder: RTL and testbench

Byte queue that sits directly upstream of the 8-bit flag/acknowledge bus crossing in the power domain. It collects bytes written by the 8080-side logic in the source clock domain and presents them one at a time to the crossing's `FlagIn_clkA`/`BusIn` inputs. It advances only when the crossing's `Busy_clkA` is low. Writers can burst several bytes without stalling on the crossing's round-trip acknowledge.

---
 rtl/cross_bus_pkg.sv | 19 +
 rtl/cross_bus_feeder_byte_ring.sv | 53 +++++
 rtl/cross_bus_feeder.sv | 71 +++++++
 tb/tb_cross_bus_feeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cross_bus_pkg.sv
// Shared types and width helpers for the cross_bus_feeder byte queue and its ring storage.
package cross_bus_pkg;

  localparam int BUS_W      = 8;
  localparam int DROP_CNT_W = 8;
  localparam int SENT_CNT_W = 16;

  typedef logic [BUS_W-1:0] bus_byte_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Level must represent DEPTH itself, hence one bit more than the pointers.
  function automatic int lvl_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/cross_bus_feeder_byte_ring.sv
// byte_ring: circular byte buffer with wrapping read/write pointers and a separate occupancy count.
module byte_ring
  import cross_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  bus_byte_t                 data,
  output bus_byte_t                 head,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  bus_byte_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) mem[wr_ptr] <= data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/cross_bus_feeder.sv
// cross_bus_feeder: byte queue feeding the flag/acknowledge bus crossing; pops only while Busy_clkA is low.
// Optional feature macro: CROSS_FEED_STATS_EN adds drop_cnt / sent_cnt counters.
module cross_bus_feeder
  import cross_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clkA,
  input  logic                      rstA_n,
  input  logic                      wr_en,
  input  logic [BUS_W-1:0]          wr_data,
  input  logic                      flush,
  input  logic                      Busy_clkA,
  output logic                      FlagIn_clkA,
  output logic [BUS_W-1:0]          BusIn,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      ovf
`ifdef CROSS_FEED_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_cnt,
  output logic [SENT_CNT_W-1:0]     sent_cnt
`endif
);

  logic pop;
  logic push;
  logic drop;

  // A pop is exactly the cycle the crossing captures BusIn.
  assign pop  = ~empty & ~Busy_clkA;
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  assign FlagIn_clkA = ~empty;

  byte_ring #(.DEPTH(DEPTH)) u_ring (
    .clk   (clkA),
    .rst_n (rstA_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .data  (wr_data),
    .head  (BusIn),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clkA) begin
    if (!rstA_n)    ovf <= 1'b0;
    else if (flush) ovf <= 1'b0;
    else if (drop)  ovf <= 1'b1;
  end

`ifdef CROSS_FEED_STATS_EN
  // sent_cnt keeps counting across flush; a pop in a flush cycle is still a delivered byte.
  always_ff @(posedge clkA) begin
    if (!rstA_n) begin
      drop_cnt <= '0;
      sent_cnt <= '0;
    end else begin
      if (flush)                        drop_cnt <= '0;
      else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      if (pop)                          sent_cnt <= sent_cnt + SENT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cross_bus_feeder.sv
// Self-checking bench for cross_bus_feeder: vector table, directed corner sequences and a queue-based reference model.
module tb_cross_bus_feeder;

  localparam int DEPTH = 8;

  logic       clkA = 1'b0;
  logic       rstA_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       Busy_clkA;
  logic       FlagIn_clkA;
  logic [7:0] BusIn;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       ovf;
`ifdef CROSS_FEED_STATS_EN
  logic [7:0]  drop_cnt;
  logic [15:0] sent_cnt;
`endif

  cross_bus_feeder #(.DEPTH(DEPTH)) dut (
    .clkA        (clkA),
    .rstA_n      (rstA_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .Busy_clkA   (Busy_clkA),
    .FlagIn_clkA (FlagIn_clkA),
    .BusIn       (BusIn),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .ovf         (ovf)
`ifdef CROSS_FEED_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .sent_cnt    (sent_cnt)
`endif
  );

  always #5 clkA = ~clkA;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain byte queue plus a crossing that stays busy xlen cycles after each capture.
  bit [7:0] q[$];
  bit [7:0] cap[$];
  bit [7:0] expq[$];
  bit       movf = 0;
  int       mdrop = 0;
  int       msent = 0;
  int       xcnt = 0;
  int       xlen = 4;
  bit       auto_x = 0;
  int       peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop;
    int sz;
    if (!rstA_n) begin
      q.delete();
      movf  = 0;
      mdrop = 0;
      msent = 0;
      return;
    end
    sz  = q.size();
    pop = (sz > 0) && !Busy_clkA;
    if (pop) begin
      cap.push_back(BusIn);
      msent = (msent + 1) % 65536;
      xcnt  = xlen;
    end else if (xcnt > 0) begin
      xcnt--;
    end
    if (flush) begin
      q.delete();
      movf  = 0;
      mdrop = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (wr_en) begin
        if (sz < DEPTH || pop) q.push_back(wr_data);
        else begin
          movf = 1;
          if (mdrop < 255) mdrop++;
        end
      end
    end
    if (q.size() > peak) peak = q.size();
  endtask

  task automatic check_all();
    chk("level", level, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("flag", FlagIn_clkA, q.size() != 0);
    chk("ovf", ovf, movf);
    if (q.size() != 0) chk("bus_head", BusIn, q[0]);
`ifdef CROSS_FEED_STATS_EN
    chk("drop_cnt", drop_cnt, mdrop);
    chk("sent_cnt", sent_cnt, msent);
`endif
  endtask

  task automatic cyc(input bit wr, input bit [7:0] d, input bit fl, input bit bz);
    wr_en     = wr;
    wr_data   = d;
    flush     = fl;
    Busy_clkA = auto_x ? (xcnt != 0) : bz;
    model_step();
    @(posedge clkA);
    @(negedge clkA);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic chk_cap(input string name);
    chk({name, "_count"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++)
      chk({name, "_byte"}, cap[i], expq[i]);
  endtask

  typedef struct {
    bit       wr;
    bit [7:0] d;
    bit       fl;
    bit       bz;
    int       lvl;
    bit       flg;
    bit       fu;
    bit       ov;
    bit [7:0] bus;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'hA0};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'hA0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'hA1};
    tbl[4] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'hA2};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 8'hB0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 8'hB1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'hB1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00};

    rstA_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; Busy_clkA = 1'b0;
    @(negedge clkA);

    // Reset with wr_en held high: nothing may be queued.
    for (int i = 0; i < 3; i++) cyc(1, 8'h5A + 8'(i), 0, 0);
    rstA_n = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_flag", FlagIn_clkA, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_full", full, 0);

    // Hand-computed vector table.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].wr, tbl[i].d, tbl[i].fl, tbl[i].bz);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_flag", FlagIn_clkA, tbl[i].flg);
      chk("tbl_full", full, tbl[i].fu);
      chk("tbl_ovf", ovf, tbl[i].ov);
      if (tbl[i].flg) chk("tbl_bus", BusIn, tbl[i].bus);
    end

    // Burst of three into a crossing busy 4 cycles per capture.
    auto_x = 1; xlen = 4; xcnt = 0; cap.delete(); peak = 0;
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    idle(20);
    expq = '{8'h11, 8'h22, 8'h33};
    chk_cap("burst3");
    chk("burst3_peak", peak, 2);

    // Overflow: busy crossing, DEPTH+1 pushes.
    auto_x = 0; cap.delete();
    for (int i = 0; i <= DEPTH; i++) cyc(1, 8'(i), 0, 1);
    chk("ovf_full", full, 1);
    chk("ovf_set", ovf, 1);
    chk("ovf_level", level, DEPTH);
`ifdef CROSS_FEED_STATS_EN
    chk("ovf_drop_cnt", drop_cnt, 1);
`endif
    auto_x = 1; xcnt = 0;
    idle(60);
    expq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    chk_cap("ovf_drain");
    chk("ovf_sticky", ovf, 1);

    // Full queue with same-cycle pop and push.
    auto_x = 0;
    cyc(0, 8'h00, 1, 1);
    chk("flush_clears_ovf", ovf, 0);
    cap.delete();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'hC0 + 8'(i), 0, 1);
    cyc(1, 8'hAA, 0, 0);
    chk("fullpp_level", level, DEPTH);
    chk("fullpp_ovf", ovf, 0);
    auto_x = 1; xcnt = 4;
    idle(60);
    expq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hAA};
    chk_cap("fullpp_order");

    // Flush together with a push: the pushed byte must not survive.
    auto_x = 0;
    for (int i = 0; i < 4; i++) cyc(1, 8'hD0 + 8'(i), 0, 1);
    cyc(1, 8'hEE, 1, 1);
    chk("flush_level", level, 0);
    chk("flush_flag", FlagIn_clkA, 0);
    chk("flush_ovf", ovf, 0);
    cyc(0, 8'h00, 0, 0);
    chk("flush_absent", FlagIn_clkA, 0);

    // Pointer wrap: 20 pushes interleaved with pops.
    auto_x = 1; xlen = 1; xcnt = 0; cap.delete(); peak = 0; expq.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'h40 + 8'(i), 0, 0);
      expq.push_back(8'h40 + 8'(i));
      cyc(0, 8'h00, 0, 0);
    end
    idle(10);
    chk_cap("wrap_order");
    chk("wrap_peak_ok", peak <= DEPTH, 1);

    // Randomized traffic against the model, including mid-run reset.
    auto_x = 0; xlen = 4; peak = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rstA_n = 1'b0;
        cyc(1, 8'($urandom), 0, 0);
        rstA_n = 1'b1;
      end
      cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) != 0);
    end
    chk("rand_peak_ok", peak <= DEPTH, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
